// File: rtl/astar_heap_pkg.sv
// Shared types and register map for the A* open-set min-heap.
// Holds the entry format, register addresses, STATUS bit positions and FSM states.
package astar_heap_pkg;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] node;
  } heap_entry_t;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_PUSH   = 3'd1;
  localparam logic [2:0] ADDR_POP    = 3'd2;
  localparam logic [2:0] ADDR_PEEK   = 3'd3;
  localparam logic [2:0] ADDR_HWM    = 3'd4;
  localparam logic [2:0] ADDR_PUSHES = 3'd5;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_UDF   = 4;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} heap_state_t;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

endpackage

// File: rtl/astar_heap_min2.sv
// Combinational child selector for sift-down: picks the smaller-key valid child,
// the left child winning ties so equal keys never move.
module astar_heap_min2
  import astar_heap_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  heap_entry_t      left_entry,
  input  heap_entry_t      right_entry,
  input  logic             left_valid,
  input  logic             right_valid,
  input  logic [IDX_W-1:0] left_idx,
  input  logic [IDX_W-1:0] right_idx,
  output logic [IDX_W-1:0] win_idx,
  output heap_entry_t      win_entry,
  output logic             win_valid
);

  always_comb begin
    win_idx   = left_idx;
    win_entry = left_entry;
    win_valid = left_valid | right_valid;
    if (right_valid && (!left_valid || (right_entry.key < left_entry.key))) begin
      win_idx   = right_idx;
      win_entry = right_entry;
    end
  end

endmodule

// File: rtl/astar_open_heap.sv
// Avalon-MM min-priority queue for the A* open set; binary heap with one swap per clock.
// Optional ASTAR_HEAP_STATS_EN adds high-water (addr 4) and total-push (addr 5) counters.
module astar_open_heap
  import astar_heap_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  heap_entry_t       heap [DEPTH];
  heap_state_t       state, state_nxt;
  logic [CNT_W-1:0]  count, idx, last, par;
  logic [CNT_W:0]    lc, rc, win_idx;
  logic              overflow, underflow;
  logic              empty, full, wr_acc, rd_acc, up_swap, dn_swap, win_valid;
  heap_entry_t       cur, pent, win_entry;
`ifdef ASTAR_HEAP_STATS_EN
  logic [CNT_W-1:0]  hwm;
  logic [31:0]       pushes;
`endif

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign wr_acc = avs_write & (state == IDLE);
  assign rd_acc = avs_read & ~avs_write & (state == IDLE);
  assign avs_waitrequest = (avs_read | avs_write) & (state != IDLE);

  assign last = count - 1'b1;
  assign par  = (idx - 1'b1) >> 1;
  // Child indices are one bit wider so 2*idx+2 cannot wrap back into range.
  assign lc   = {idx, 1'b1};
  assign rc   = lc + 1'b1;
  assign cur  = heap[idx[AW-1:0]];
  assign pent = heap[par[AW-1:0]];

  astar_heap_min2 #(.IDX_W(CNT_W + 1)) u_min2 (
    .left_entry  (heap[lc[AW-1:0]]),
    .right_entry (heap[rc[AW-1:0]]),
    .left_valid  (lc < {1'b0, count}),
    .right_valid (rc < {1'b0, count}),
    .left_idx    (lc),
    .right_idx   (rc),
    .win_idx     (win_idx),
    .win_entry   (win_entry),
    .win_valid   (win_valid)
  );

  assign up_swap = (idx != '0) && (cur.key < pent.key);
  assign dn_swap = win_valid && (win_entry.key < cur.key);

  always_comb begin
    state_nxt    = state;
    avs_readdata = '0;
    case (state)
      IDLE: begin
        if (wr_acc && avs_address == ADDR_PUSH && !full)
          state_nxt = SIFT_UP;
        else if (rd_acc && avs_address == ADDR_POP && !empty && last > CNT_W'(1))
          state_nxt = SIFT_DOWN;
      end
      // Leaving straight after a swap into the root keeps push within log2(DEPTH) busy cycles.
      SIFT_UP:   state_nxt = (up_swap && par != '0) ? SIFT_UP : IDLE;
      SIFT_DOWN: state_nxt = dn_swap ? SIFT_DOWN : IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (rd_acc) begin
      case (avs_address)
        ADDR_STATUS: avs_readdata = {16'(count), 11'b0, underflow, overflow, full, empty,
                                     (state != IDLE)};
        ADDR_POP, ADDR_PEEK: avs_readdata = empty ? EMPTY_READ : heap[0];
`ifdef ASTAR_HEAP_STATS_EN
        ADDR_HWM:    avs_readdata = {16'b0, 16'(hwm)};
        ADDR_PUSHES: avs_readdata = pushes;
`endif
        default:     avs_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) heap[i] <= '0;
`ifdef ASTAR_HEAP_STATS_EN
      hwm       <= '0;
      pushes    <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wr_acc) begin
            case (avs_address)
              ADDR_STATUS: begin
                if (avs_writedata[0])      count     <= '0;
                if (avs_writedata[ST_OVF]) overflow  <= 1'b0;
                if (avs_writedata[ST_UDF]) underflow <= 1'b0;
              end
              ADDR_PUSH: begin
                if (full) begin
                  overflow <= 1'b1;
                end else begin
                  heap[count[AW-1:0]] <= heap_entry_t'(avs_writedata);
                  idx   <= count;
                  count <= count + 1'b1;
`ifdef ASTAR_HEAP_STATS_EN
                  pushes <= pushes + 32'd1;
                  if ((count + 1'b1) > hwm) hwm <= count + 1'b1;
`endif
                end
              end
`ifdef ASTAR_HEAP_STATS_EN
              ADDR_HWM: hwm <= count;
`endif
              default: ;
            endcase
          end else if (rd_acc && avs_address == ADDR_POP) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              heap[0] <= heap[last[AW-1:0]];
              count   <= last;
              idx     <= '0;
            end
          end
        end
        SIFT_UP: begin
          if (up_swap) begin
            heap[idx[AW-1:0]] <= pent;
            heap[par[AW-1:0]] <= cur;
            idx <= par;
          end
        end
        SIFT_DOWN: begin
          if (dn_swap) begin
            heap[idx[AW-1:0]]     <= win_entry;
            heap[win_idx[AW-1:0]] <= cur;
            idx <= CNT_W'(win_idx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/astar_open_heap.md
Name: astar_open_heap

Overview:
- Hardware min-priority queue holding the A* open set, so the Nios II does not maintain a software heap in SDRAM.
- Avalon-MM slave instantiated inside nios2_system on the CPU data master, alongside the LED PIO and SDRAM controller.
- CPU pushes {f-cost key, node id} words and pops the minimum-key entry.
- Binary heap in a register array; a sift FSM restores heap order one swap per clock.

Parameters:
- DEPTH, 64, heap capacity in entries. Power of two, 2..256.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, readLatency 0 (valid in the cycle the access completes)
- avs_waitrequest  out  1  stall the current access

Behaviour:
- Entry format: bits [31:16] key (unsigned), bits [15:0] node id. Ordering uses the key only, with strict less-than comparison, so equal keys never swap.
- Register map:
  - 0 STATUS (R): bit0 busy, bit1 empty, bit2 full, bit3 overflow (sticky), bit4 underflow (sticky), [31:16] count.
  - 0 STATUS (W): bit0=1 clears the heap (count=0); bits3/4 write-1-to-clear.
  - 1 PUSH (W): insert writedata.
  - 2 POP (R): return the root and remove it.
  - 3 PEEK (R): return the root without removing it.
  - 4 reserved (see Optional Feature); reads 0 when unused.
  - Other addresses: read 0, writes ignored.
- Reset values: count=0, flags=0, state IDLE, avs_readdata=0, avs_waitrequest=0, all heap entries 0.
- Reset asserted mid-sift aborts immediately; the heap is empty afterwards.
- waitrequest = (avs_read|avs_write) & (state != IDLE). Accesses complete only in IDLE; STATUS therefore never reads busy=1 from the CPU.
- FSM states and transitions:
  - IDLE:
    - PUSH, not full: heap[count]<=data, idx<=count, count++, go to SIFT_UP.
    - PUSH while full: entry dropped, overflow set, stay IDLE.
    - POP, not empty: readdata=heap[0] this cycle, heap[0]<=heap[count-1], count--, idx<=0.
      - Go to SIFT_DOWN if the new count>1, else stay IDLE.
    - POP/PEEK while empty: readdata=32'hFFFF_FFFF; underflow set on POP only.
  - SIFT_UP: p=(idx-1)>>1.
    - idx==0, or key[idx] >= key[p]: go to IDLE.
    - Otherwise: swap idx and p, idx<=p.
  - SIFT_DOWN: l=2idx+1, r=2idx+2; consider only children with index < count.
    - Pick the smaller child key; left wins ties.
    - Child key < key[idx]: swap, idx<=child.
    - Otherwise, or no children: go to IDLE.
- Latency:
  - Push and pop occupy at most log2(DEPTH) busy cycles after the accepting cycle.
  - A back-to-back access stalls via waitrequest until IDLE.
- A clear write during IDLE wins over any other effect in that cycle. Heap contents are not zeroed; only count is reset.
- Simultaneous read and write is illegal; the write takes priority and the read returns 0.
- count never exceeds DEPTH; index arithmetic is CNT_W bits wide, so no wrap is possible.

Optional Feature:
- Macro: ASTAR_HEAP_STATS_EN.
- With the macro:
  - Address 4 reads {16'b0, high-water count}; writing any value to address 4 resets it to the current count.
  - Address 5 reads the total successful pushes, 32-bit, wrapping.
  - Both counters are 0 after reset.
- Without the macro: addresses 4 and 5 read 0, and no counter logic is present.

Decomposition:
- Package astar_heap_pkg holds:
  - heap_entry_t packed struct {key[15:0], node[15:0]}
  - register address localparams ADDR_STATUS..ADDR_PUSHES
  - STATUS bit-index constants
  - state enum {IDLE, SIFT_UP, SIFT_DOWN}
  - EMPTY_READ constant 32'hFFFF_FFFF
- One sub-module: astar_heap_min2, combinational child selector. Inputs: two entries plus valid flags. Outputs: the winning index and entry, with the left-tie rule.

Test Plan:
- Push keys 5,3,8,1 (nodes 10..13), then pop ×4 -> readdata 0x0001000D, 0x0003000B, 0x0005000A, 0x0008000C; STATUS then shows empty=1, count=0.
- Pop on an empty heap -> 0xFFFFFFFF and underflow=1; write STATUS=0x10 -> underflow=0.
- DEPTH=4: push 5 entries -> fifth dropped, overflow=1, full=1, count=4; the next pop returns the minimum of the first four.
- Push descending keys 64..1 (DEPTH=64) back-to-back -> waitrequest stalls each write ≤6 cycles; pops return keys 1..64 in order.
- Equal keys: push 0x00070001 then 0x00070002 -> pop returns node 1 first (no swap on equal keys).
- Assert reset_reset_n low during SIFT_DOWN -> waitrequest drops asynchronously; afterwards STATUS=0x00000002 (empty, count 0).
